// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: branch-unit redirect, hazard stall, imem handshake and IF/ID outputs.
// With IF_PERF_CNT_EN defined, the perf counter outputs are carried here as well.
interface if_fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            mux_to_pc;
  logic [XLEN-1:0] branch_target;
  logic            IF_Flush;
  logic            stall;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            imem_valid;
  logic [XLEN-1:0] if_id_pc;
  logic [31:0]     if_id_instr;
  logic            if_id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0]     perf_flush_cnt;
  logic [31:0]     perf_wait_cnt;

  modport master (
    input  mux_to_pc, branch_target, IF_Flush, stall, imem_rdata, imem_valid,
    output imem_req, imem_addr, if_id_pc, if_id_instr, if_id_valid,
           perf_flush_cnt, perf_wait_cnt
  );
  modport slave (
    output mux_to_pc, branch_target, IF_Flush, stall, imem_rdata, imem_valid,
    input  imem_req, imem_addr, if_id_pc, if_id_instr, if_id_valid,
           perf_flush_cnt, perf_wait_cnt
  );
`else
  modport master (
    input  mux_to_pc, branch_target, IF_Flush, stall, imem_rdata, imem_valid,
    output imem_req, imem_addr, if_id_pc, if_id_instr, if_id_valid
  );
  modport slave (
    output mux_to_pc, branch_target, IF_Flush, stall, imem_rdata, imem_valid,
    input  imem_req, imem_addr, if_id_pc, if_id_instr, if_id_valid
  );
`endif
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, single-outstanding imem handshake, IF/ID register with flush/stall.
// Optional IF_PERF_CNT_EN adds saturating flush-cycle and wait-cycle counters.
module if_fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input logic            clk,
  input logic            reset,
  if_fetch_stage_if.master bus
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT, S_DROP} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_redirect_pc;
  logic            r_redirect_pend;
  logic            r_buf_valid;
  logic [XLEN-1:0] r_buf_pc;
  logic [31:0]     r_buf_instr;
  logic [XLEN-1:0] r_if_id_pc;
  logic [31:0]     r_if_id_instr;
  logic            r_if_id_valid;

  logic            w_req;
  logic            w_accept;
  logic            w_buf_load;
  logic [XLEN-1:0] w_pc_inc;

  // FETCH withholds the request while stalled or while the skid buffer is full;
  // WAIT/DROP keep it up so the outstanding request is never retracted.
  always_comb begin
    w_req = 1'b0;
    case (r_state)
      S_FETCH: w_req = !bus.stall && !r_buf_valid;
      S_WAIT:  w_req = 1'b1;
      S_DROP:  w_req = r_redirect_pend;
      default: w_req = 1'b0;
    endcase
  end

  // A response is taken only for a live request in FETCH/WAIT and never alongside a redirect.
  assign w_accept   = bus.imem_valid && w_req && !bus.mux_to_pc &&
                      (r_state == S_FETCH || r_state == S_WAIT);
  assign w_buf_load = r_buf_valid && !bus.stall && !bus.mux_to_pc;
  assign w_pc_inc   = r_pc + XLEN'(4);

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_pc;
  assign bus.if_id_pc    = r_if_id_pc;
  assign bus.if_id_instr = r_if_id_instr;
  assign bus.if_id_valid = r_if_id_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_BOOT;
      r_pc            <= RESET_PC;
      r_redirect_pc   <= RESET_PC;
      r_redirect_pend <= 1'b0;
      r_buf_valid     <= 1'b0;
      r_buf_pc        <= '0;
      r_buf_instr     <= NOP_INSTR;
      r_if_id_pc      <= '0;
      r_if_id_instr   <= NOP_INSTR;
      r_if_id_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state <= S_FETCH;
          if (bus.mux_to_pc) begin
            r_pc        <= bus.branch_target;
            r_buf_valid <= 1'b0;
          end
        end
        S_FETCH: begin
          if (bus.mux_to_pc) begin
            r_pc        <= bus.branch_target;
            r_buf_valid <= 1'b0;
          end else if (w_req && !bus.imem_valid) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mux_to_pc && bus.imem_valid) begin
            r_pc    <= bus.branch_target;
            r_state <= S_FETCH;
          end else if (bus.mux_to_pc) begin
            r_redirect_pc   <= bus.branch_target;
            r_redirect_pend <= 1'b1;
            r_state         <= S_DROP;
          end else if (bus.imem_valid) begin
            r_state <= S_FETCH;
          end
        end
        S_DROP: begin
          // The stale response is thrown away; a same-cycle redirect is the newest target.
          if (bus.imem_valid) begin
            r_pc            <= bus.mux_to_pc ? bus.branch_target : r_redirect_pc;
            r_redirect_pend <= 1'b0;
            r_state         <= S_FETCH;
          end else if (bus.mux_to_pc) begin
            r_redirect_pc <= bus.branch_target;
          end
        end
        default: r_state <= S_BOOT;
      endcase

      if (w_accept) begin
        r_pc <= w_pc_inc;
        if (bus.stall) begin
          r_buf_valid <= 1'b1;
          r_buf_pc    <= r_pc;
          r_buf_instr <= bus.imem_rdata;
        end
      end

      // IF/ID: flush beats stall, stall holds, otherwise load new/buffered instr or a bubble.
      if (bus.IF_Flush) begin
        r_if_id_pc    <= '0;
        r_if_id_instr <= NOP_INSTR;
        r_if_id_valid <= 1'b0;
        r_buf_valid   <= 1'b0;
      end else if (bus.stall) begin
        r_if_id_valid <= r_if_id_valid;
      end else if (w_accept) begin
        r_if_id_pc    <= r_pc;
        r_if_id_instr <= bus.imem_rdata;
        r_if_id_valid <= 1'b1;
      end else if (w_buf_load) begin
        r_if_id_pc    <= r_buf_pc;
        r_if_id_instr <= r_buf_instr;
        r_if_id_valid <= 1'b1;
        r_buf_valid   <= 1'b0;
      end else begin
        r_if_id_pc    <= '0;
        r_if_id_instr <= NOP_INSTR;
        r_if_id_valid <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_flush_cnt;
  logic [31:0] r_perf_wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_flush_cnt <= '0;
      r_perf_wait_cnt  <= '0;
    end else begin
      if (bus.IF_Flush && r_perf_flush_cnt != 32'hFFFF_FFFF)
        r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      if ((r_state == S_WAIT || r_state == S_DROP) && r_perf_wait_cnt != 32'hFFFF_FFFF)
        r_perf_wait_cnt <= r_perf_wait_cnt + 32'd1;
    end
  end

  assign bus.perf_flush_cnt = r_perf_flush_cnt;
  assign bus.perf_wait_cnt  = r_perf_wait_cnt;
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage sitting directly downstream of the branch unit.
- Consumes mux_to_pc and IF_Flush, and owns the PC register and the imem request handshake (one outstanding request).
- Drives the IF/ID pipeline register: squashes it to a NOP on a flush and holds it on a hazard stall.

Parameters:
- XLEN, 32, PC/instruction width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction inserted into IF/ID on flush or bubble (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mux_to_pc  in  1  redirect request from the branch unit; PC takes branch_target.
- branch_target  in  XLEN  redirect address, valid when mux_to_pc=1.
- IF_Flush  in  1  squash the IF/ID register this cycle.
- stall  in  1  hazard-unit stall: hold PC and IF/ID, issue no new request.
- imem_req  out  1  fetch request, level.
- imem_addr  out  XLEN  fetch address, stable while imem_req=1 and unanswered.
- imem_rdata  in  32  instruction, valid with imem_valid.
- imem_valid  in  1  response strobe; may assert in the same cycle as imem_req (zero-wait).
- if_id_pc  out  XLEN  PC of the instruction in IF/ID.
- if_id_instr  out  32  instruction in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset is asynchronous and active-high:
  - pc=RESET_PC; state=BOOT.
  - imem_req=0; imem_addr=RESET_PC.
  - if_id_pc=0; if_id_instr=NOP_INSTR; if_id_valid=0.
  - buf_valid=0; redirect_pend=0.
- FSM states: BOOT, FETCH, WAIT, DROP.
  - BOOT: one cycle with no request after reset deasserts, then FETCH.
  - FETCH: imem_req = !stall, imem_addr = pc.
    - If valid arrives in the same cycle, the response is accepted.
    - If no valid arrives, go to WAIT.
  - WAIT: imem_req=1, imem_addr held, no matter what stall is.
    - Exit to FETCH on imem_valid.
  - DROP: entered when a redirect occurs while in WAIT. imem_req and imem_addr are held.
    - On imem_valid the response is discarded; pc=redirect_pc; go to FETCH.
- Accepted response with stall=0 and no flush:
  - IF/ID <= {pc, imem_rdata, 1}; pc <= pc+4. Wrap-around modulo 2^XLEN.
  - Fetch-to-IF/ID latency: 1 cycle after the accept edge.
- Accepted response with stall=1: captured in a 1-entry buffer {pc, instr}.
  - pc <= pc+4; no new request while buf_valid=1.
  - When stall drops, the buffer loads IF/ID and buf_valid clears.
- stall=1 (no flush): IF/ID holds its value and pc is frozen, except for the buffer capture above.
- Redirect (mux_to_pc=1): takes priority over stall and over a response.
  - In FETCH/BOOT: pc <= branch_target; any same-cycle response is discarded; buf_valid <= 0.
  - In WAIT without a same-cycle valid: redirect_pc <= branch_target; go to DROP.
  - In WAIT with a same-cycle valid: pc <= branch_target; go to FETCH.
  - In DROP: redirect_pc is updated; the last redirect wins.
- IF_Flush=1: IF/ID <= {0, NOP_INSTR, 0} at the next edge, overriding stall and any accept. buf_valid clears.
- mux_to_pc without IF_Flush is legal: the redirect happens and IF/ID is not squashed.
- imem_valid outside FETCH-with-req, WAIT or DROP is ignored.
- Reset mid-request: everything returns to reset values. A late imem_valid after reset is ignored, because BOOT issues no request.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_flush_cnt[31:0] (count of cycles with IF_Flush=1) and perf_wait_cnt[31:0] (count of cycles in WAIT or DROP).
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset release, zero-wait memory, rdata=pc^32'hA5A5_0000 → imem_addr sequence 0,4,8,C. IF/ID shows pc 0 one cycle after the first accept; if_id_valid=1.
- Branch unit pulses mux_to_pc=1, IF_Flush=1, branch_target=32'h100 during sequential fetch → IF/ID = {0, 32'h13, 0} next cycle; the following fetch address is 32'h100.
- 3-cycle memory latency, redirect to 32'h200 in the 2nd wait cycle → imem_addr stays at the old pc until valid. The response is dropped, the next imem_addr is 32'h200, and no stale instruction reaches IF/ID.
- stall=1 for 4 cycles while a response arrives in cycle 2 → IF/ID is unchanged and no new imem_req is issued. When stall drops, IF/ID gets the buffered instr, then fetch resumes at pc+4.
- pc=32'hFFFF_FFFC, sequential fetch → next imem_addr = 32'h0000_0000.
- Assert reset while in WAIT, then deliver imem_valid after release → all outputs return to reset values; the late valid is ignored; the first fetch is RESET_PC.
